// File: rtl/shift_unit.sv
`default_nettype none
// ============================================================================
// Module   : shift_unit
// Purpose  : Multi-cycle barrel shifter (SLL/SRL/SRA/ROL) with a valid/ready
//            handshake. One log-shifter stage per cycle: SHW cycles/result.
// Revision : 1.0  initial release
// ============================================================================
module shift_unit #(
  parameter int WIDTH = 32,   // data width, power of two, >= 4
  parameter int SHW   = 5     // log2(WIDTH)
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] data_in,
  input  logic [SHW-1:0]   shamt,
  input  logic [1:0]       mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] data_out,
  output logic             busy
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  localparam logic [1:0] M_SLL = 2'b00;
  localparam logic [1:0] M_SRL = 2'b01;
  localparam logic [1:0] M_SRA = 2'b10;

  localparam logic [SHW-1:0] K_TOP = SHW'(SHW - 1);

  logic [1:0]       state_q, state_d;
  logic [SHW-1:0]   k_q, k_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [SHW-1:0]   shamt_q, shamt_d;
  logic [1:0]       mode_q, mode_d;

  logic             stage_en;
  logic [SHW:0]     stage_amt;
  logic [SHW:0]     stage_ramt;
  logic [WIDTH-1:0] stage_out;

  // One log-shifter stage: shift by 2^k when the captured shamt bit k is set.
  // SRA stays correct across stages because each step preserves the MSB.
  always_comb begin
    stage_en = 1'b0;
    for (int i = 0; i < SHW; i++) begin
      if (k_q == SHW'(i)) stage_en = shamt_q[i];
    end
    stage_amt  = (SHW+1)'(1) << k_q;
    stage_ramt = (SHW+1)'(WIDTH) - stage_amt;
    stage_out  = data_q;
    if (stage_en) begin
      case (mode_q)
        M_SLL:   stage_out = data_q << stage_amt;
        M_SRL:   stage_out = data_q >> stage_amt;
        M_SRA:   stage_out = $signed(data_q) >>> stage_amt;
        default: stage_out = (data_q << stage_amt) | (data_q >> stage_ramt);
      endcase
    end
  end

  // Next-state logic: capture in IDLE, walk stages k=SHW-1..0, hold in DONE.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    data_d  = data_q;
    shamt_d = shamt_q;
    mode_d  = mode_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          data_d  = data_in;
          shamt_d = shamt;
          mode_d  = mode;
          k_d     = K_TOP;
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        data_d = stage_out;
        if (k_q == '0) begin
          k_d     = K_TOP;
          state_d = S_DONE;
        end else begin
          k_d = k_q - SHW'(1);
        end
      end
      S_DONE: begin
        // The consuming edge only returns to IDLE; a new request waits a cycle.
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers; reset clears everything immediately and drops any work.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      k_q     <= K_TOP;
      data_q  <= '0;
      shamt_q <= '0;
      mode_q  <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      data_q  <= data_d;
      shamt_q <= shamt_d;
      mode_q  <= mode_d;
    end
  end

  // in_ready is gated by resetn so it reads 0 during reset, not just after.
  assign in_ready  = resetn & (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign busy      = (state_q != S_IDLE);
  assign data_out  = data_q;

endmodule
`default_nettype wire

// File: tb/tb_shift_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_shift_unit
// Purpose  : Self-checking bench for shift_unit at WIDTH=32 and WIDTH=8,
//            directed cases plus random regression against a bit-level model.
// Revision : 1.0  initial release
// ============================================================================
module tb_shift_unit;

  logic        clock;
  logic        resetn;

  logic        iv32, ir32, ov32, or32, bz32;
  logic [31:0] di32, do32;
  logic [4:0]  sh32;
  logic [1:0]  md32;

  logic        iv8, ir8, ov8, or8, bz8;
  logic [7:0]  di8, do8;
  logic [2:0]  sh8;
  logic [1:0]  md8;

  int vectors     = 0;
  int miscompares = 0;

  shift_unit #(.WIDTH(32), .SHW(5)) dut32 (
    .clock(clock), .resetn(resetn),
    .in_valid(iv32), .in_ready(ir32), .data_in(di32), .shamt(sh32), .mode(md32),
    .out_valid(ov32), .out_ready(or32), .data_out(do32), .busy(bz32)
  );

  shift_unit #(.WIDTH(8), .SHW(3)) dut8 (
    .clock(clock), .resetn(resetn),
    .in_valid(iv8), .in_ready(ir8), .data_in(di8), .shamt(sh8), .mode(md8),
    .out_valid(ov8), .out_ready(or8), .data_out(do8), .busy(bz8)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Bit-level reference: each output bit picks its source bit by the mode rule.
  function automatic logic [31:0] ref_model(input int w, input logic [31:0] d,
                                            input int s, input logic [1:0] m);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < w; i++) begin
      case (m)
        2'b00:   r[i] = (i >= s)    ? d[i-s] : 1'b0;
        2'b01:   r[i] = (i + s < w) ? d[i+s] : 1'b0;
        2'b10:   r[i] = (i + s < w) ? d[i+s] : d[w-1];
        default: r[i] = d[(i - s + w) % w];
      endcase
    end
    return r;
  endfunction

  function automatic logic f_ov(input bit n8); return n8 ? ov8 : ov32; endfunction
  function automatic logic f_ir(input bit n8); return n8 ? ir8 : ir32; endfunction
  function automatic logic f_bz(input bit n8); return n8 ? bz8 : bz32; endfunction
  function automatic logic [31:0] f_do(input bit n8);
    return n8 ? {24'h0, do8} : do32;
  endfunction

  task automatic drive_req(input bit n8, input logic v, input logic [31:0] d,
                           input int s, input logic [1:0] m);
    if (n8) begin
      iv8 = v; di8 = d[7:0]; sh8 = s[2:0]; md8 = m;
    end else begin
      iv32 = v; di32 = d; sh32 = s[4:0]; md32 = m;
    end
  endtask

  task automatic set_ordy(input bit n8, input logic v);
    if (n8) or8 = v; else or32 = v;
  endtask

  // Full transaction: accept, measure latency, check result, optional
  // back-pressure hold, consume.
  task automatic run_op(input bit n8, input logic [31:0] d, input int s,
                        input logic [1:0] m, input logic [31:0] want,
                        input bit scramble, input int hold, input string tag);
    int          lat;
    int          lat_exp;
    logic [31:0] want_m;
    lat_exp = n8 ? 3 : 5;
    want_m  = n8 ? {24'h0, want[7:0]} : want;

    vectors++;
    if (f_ir(n8) !== 1'b1) begin
      miscompares++;
      $display("FAIL %s in_ready_idle: got %b want 1", tag, f_ir(n8));
    end
    drive_req(n8, 1'b1, d, s, m);
    @(posedge clock); #1;
    drive_req(n8, 1'b0, d, s, m);
    vectors++;
    if (f_bz(n8) !== 1'b1 || f_ir(n8) !== 1'b0) begin
      miscompares++;
      $display("FAIL %s shift_flags: got busy=%b in_ready=%b want busy=1 in_ready=0",
               tag, f_bz(n8), f_ir(n8));
    end
    lat = 0;
    while (f_ov(n8) !== 1'b1 && lat < 20) begin
      if (scramble)
        drive_req(n8, 1'($urandom_range(0, 1)), $urandom,
                  int'($urandom_range(0, 31)), 2'($urandom_range(0, 3)));
      @(posedge clock); #1;
      lat++;
    end
    vectors++;
    if (lat != lat_exp) begin
      miscompares++;
      $display("FAIL %s latency: got %0d want %0d", tag, lat, lat_exp);
    end
    vectors++;
    if (f_do(n8) !== want_m) begin
      miscompares++;
      $display("FAIL %s data_out: got %h want %h", tag, f_do(n8), want_m);
    end
    for (int h = 0; h < hold; h++) begin
      @(posedge clock); #1;
      vectors++;
      if (f_ov(n8) !== 1'b1 || f_ir(n8) !== 1'b0 || f_do(n8) !== want_m) begin
        miscompares++;
        $display("FAIL %s hold%0d: got ov=%b ir=%b do=%h want ov=1 ir=0 do=%h",
                 tag, h, f_ov(n8), f_ir(n8), f_do(n8), want_m);
      end
    end
    drive_req(n8, 1'b0, d, s, m);
    set_ordy(n8, 1'b1);
    @(posedge clock); #1;
    set_ordy(n8, 1'b0);
    vectors++;
    if (f_ov(n8) !== 1'b0 || f_ir(n8) !== 1'b1 || f_bz(n8) !== 1'b0) begin
      miscompares++;
      $display("FAIL %s consume: got ov=%b ir=%b busy=%b want 0 1 0",
               tag, f_ov(n8), f_ir(n8), f_bz(n8));
    end
  endtask

  task automatic test_reset;
    resetn = 1'b0;
    #2;
    vectors++;
    if (ov32 !== 1'b0 || bz32 !== 1'b0 || do32 !== 32'h0 || ir32 !== 1'b0) begin
      miscompares++;
      $display("FAIL reset32: got ov=%b busy=%b do=%h ir=%b want 0 0 0 0",
               ov32, bz32, do32, ir32);
    end
    vectors++;
    if (ov8 !== 1'b0 || bz8 !== 1'b0 || do8 !== 8'h0 || ir8 !== 1'b0) begin
      miscompares++;
      $display("FAIL reset8: got ov=%b busy=%b do=%h ir=%b want 0 0 0 0",
               ov8, bz8, do8, ir8);
    end
    #10 resetn = 1'b1;
    @(posedge clock); #1;
    vectors++;
    if (ir32 !== 1'b1 || ir8 !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_release in_ready: got %b/%b want 1/1", ir32, ir8);
    end
  endtask

  task automatic test_directed;
    run_op(0, 32'h0000FFFF, 16, 2'b00, 32'hFFFF0000, 0, 0, "sll16");
    run_op(0, 32'h80000000, 31, 2'b10, 32'hFFFFFFFF, 0, 0, "sra31");
    run_op(0, 32'h80000000, 31, 2'b01, 32'h00000001, 0, 0, "srl31");
    run_op(0, 32'h80000001, 1,  2'b11, 32'h00000003, 0, 0, "rol1");
    for (int m = 0; m < 4; m++)
      run_op(0, 32'hA5A5A5A5, 0, 2'(m), 32'hA5A5A5A5, 0, 0, "shamt0");
  endtask

  task automatic test_backpressure;
    run_op(0, 32'h12345678, 12, 2'b11, 32'h45678123, 0, 3, "bp_hold");
    run_op(0, 32'hF0000000, 3,  2'b10, 32'hFE000000, 1, 0, "scramble");
  endtask

  task automatic test_back_to_back;
    int lat;
    drive_req(0, 1'b1, 32'h12345678, 4, 2'b00);
    @(posedge clock); #1;
    drive_req(0, 1'b0, 32'h0, 0, 2'b00);
    lat = 0;
    while (ov32 !== 1'b1 && lat < 20) begin
      @(posedge clock); #1; lat++;
    end
    vectors++;
    if (ov32 !== 1'b1 || do32 !== 32'h23456780) begin
      miscompares++;
      $display("FAIL b2b first: got ov=%b do=%h want 1 23456780", ov32, do32);
    end
    drive_req(0, 1'b1, 32'hCAFE0000, 8, 2'b01);
    or32 = 1'b1;
    @(posedge clock); #1;
    or32 = 1'b0;
    vectors++;
    if (bz32 !== 1'b0 || ov32 !== 1'b0 || ir32 !== 1'b1) begin
      miscompares++;
      $display("FAIL b2b no_accept_on_consume: got busy=%b ov=%b ir=%b want 0 0 1",
               bz32, ov32, ir32);
    end
    @(posedge clock); #1;
    drive_req(0, 1'b0, 32'h0, 0, 2'b00);
    vectors++;
    if (bz32 !== 1'b1) begin
      miscompares++;
      $display("FAIL b2b second_accept: got busy=%b want 1", bz32);
    end
    lat = 0;
    while (ov32 !== 1'b1 && lat < 20) begin
      @(posedge clock); #1; lat++;
    end
    vectors++;
    if (lat != 5 || do32 !== 32'h00CAFE00) begin
      miscompares++;
      $display("FAIL b2b second: got lat=%0d do=%h want 5 00cafe00", lat, do32);
    end
    or32 = 1'b1;
    @(posedge clock); #1;
    or32 = 1'b0;
  endtask

  task automatic test_reset_mid;
    bit saw_valid;
    drive_req(0, 1'b1, 32'hDEADBEEF, 7, 2'b11);
    @(posedge clock); #1;
    drive_req(0, 1'b0, 32'h0, 0, 2'b00);
    @(posedge clock); #1;
    @(posedge clock); #1;
    resetn = 1'b0;
    #1;
    vectors++;
    if (ov32 !== 1'b0 || bz32 !== 1'b0 || do32 !== 32'h0 || ir32 !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_mid: got ov=%b busy=%b do=%h ir=%b want 0 0 0 0",
               ov32, bz32, do32, ir32);
    end
    @(posedge clock); #4;
    resetn = 1'b1;
    saw_valid = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clock); #1;
      if (ov32 !== 1'b0 || bz32 !== 1'b0) saw_valid = 1'b1;
    end
    vectors++;
    if (saw_valid) begin
      miscompares++;
      $display("FAIL reset_mid_release: got stale activity=1 want 0");
    end
    run_op(0, 32'h00000001, 4, 2'b00, 32'h00000010, 0, 0, "post_reset");
  endtask

  task automatic test_width8;
    run_op(1, 32'h00000090, 2, 2'b10, 32'h000000E4, 0, 0, "w8_sra");
    for (int i = 0; i < 60; i++) begin
      logic [31:0] d;
      int          s;
      logic [1:0]  m;
      d = {24'h0, 8'($urandom)};
      s = int'($urandom_range(0, 7));
      m = 2'($urandom_range(0, 3));
      run_op(1, d, s, m, ref_model(8, d, s, m), 0, 0, "rand8");
    end
  endtask

  task automatic test_random;
    for (int i = 0; i < 150; i++) begin
      logic [31:0] d;
      int          s;
      logic [1:0]  m;
      d = $urandom;
      s = int'($urandom_range(0, 31));
      m = 2'($urandom_range(0, 3));
      run_op(0, d, s, m, ref_model(32, d, s, m), (i % 7) == 0,
             int'($urandom_range(0, 2)), "rand32");
    end
  endtask

  initial begin
    iv32 = 1'b0; di32 = '0; sh32 = '0; md32 = '0; or32 = 1'b0;
    iv8  = 1'b0; di8  = '0; sh8  = '0; md8  = '0; or8  = 1'b0;
    test_reset();
    test_directed();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    test_width8();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/shift_unit.md
SHIFT_UNIT -- requirements
Module: shift_unit

Interface
REQ-001 Parameter WIDTH, default 32, data width in bits; SHALL be a power of two, at least 4.
REQ-002 Parameter SHW, default 5, shift-amount width; SHALL equal log2(WIDTH).
REQ-003 clock  input  1  single clock for the block, all state changes on rising edge.
REQ-004 resetn  input  1  reset, asynchronous, active-low.
REQ-005 in_valid  input  1  request present on data_in/shamt/mode.
REQ-006 in_ready  output  1  block can accept a request.
REQ-007 data_in  input  WIDTH  operand.
REQ-008 shamt  input  SHW  shift amount, unsigned, 0..WIDTH-1.
REQ-009 mode  input  2  00 SLL, 01 SRL, 10 SRA, 11 ROL.
REQ-010 out_valid  output  1  result on data_out is valid.
REQ-011 out_ready  input  1  consumer accepts result.
REQ-012 data_out  output  WIDTH  shift result.
REQ-013 busy  output  1  high in any state other than IDLE.

Function
REQ-014 The block SHALL use a three-state FSM: IDLE, SHIFT, DONE.
REQ-015 IDLE: in_ready=1, out_valid=0; on in_valid=1, capture data_in, shamt and mode into internal registers, load stage index k=SHW-1, and go to SHIFT.
REQ-016 SHIFT: in_ready=0; each edge SHALL apply stage k, which shifts by 2^k when captured shamt[k]=1 and passes the data through otherwise, then decrements k.
REQ-017 After the edge that applies stage k=0, the FSM SHALL enter DONE.
REQ-018 Latency SHALL be exactly SHW cycles: an accept on edge E0 gives out_valid=1 after edge E0+SHW (5 cycles for WIDTH=32), independent of the shamt value.
REQ-019 DONE: out_valid=1, in_ready=0, and data_out SHALL hold stable while out_ready=0.
REQ-020 DONE: on out_ready=1, the FSM SHALL return to IDLE on that edge, with out_valid=0 in the next cycle.
REQ-021 No request SHALL be accepted in the cycle a result is consumed; the earliest next accept is the following cycle, in IDLE.
REQ-022 in_valid SHALL be ignored in SHIFT and DONE; input changes there SHALL NOT affect the result.
REQ-023 SLL SHALL fill vacated LSBs with 0.
REQ-024 SRL SHALL fill vacated MSBs with 0.
REQ-025 SRA SHALL fill vacated MSBs with the captured data_in[WIDTH-1].
REQ-026 ROL SHALL re-insert bits leaving the MSB end at the LSB end.
REQ-027 shamt=0 SHALL return data_in unchanged after the full SHW-cycle latency.
REQ-028 Results SHALL be bit-exact, with no width extension or truncation beyond WIDTH.
REQ-029 data_out SHALL be driven from a register.
REQ-030 data_out SHALL be don't-care while out_valid=0; the verification bench SHALL NOT check it then.

Reset
REQ-031 resetn=0 SHALL immediately force, without waiting for a clock edge: state=IDLE, k=SHW-1, data_out=0, out_valid=0, busy=0.
REQ-032 in_ready SHALL be 0 while resetn=0, and 1 from the first cycle after resetn deasserts.
REQ-033 Reset asserted during SHIFT or DONE SHALL discard the in-flight operation; no result SHALL be presented after the release of reset.
REQ-034 Reset deassertion is synchronised externally; the block SHALL NOT add a synchroniser.

Verification
REQ-035 WIDTH=32, SLL, data_in=0x0000FFFF, shamt=16 -> out_valid high exactly 5 cycles after accept, data_out=0xFFFF0000.
REQ-036 SRA, data_in=0x80000000, shamt=31 -> data_out=0xFFFFFFFF. SRL with the same operands -> 0x00000001.
REQ-037 ROL, data_in=0x80000001, shamt=1 -> 0x00000003. shamt=0 with any mode, data_in=0xA5A5A5A5 -> 0xA5A5A5A5 after 5 cycles.
REQ-038 Back-pressure: hold out_ready=0 for 3 cycles in DONE -> data_out and out_valid stable, in_ready=0. Toggle in_valid and data_in during SHIFT -> no effect on the result.
REQ-039 Reset mid-operation: assert resetn=0 at the 3rd SHIFT cycle -> outputs clear at once, no out_valid after release. The next request, SLL 0x1 by 4, -> 0x10.
REQ-040 Parameter sweep: WIDTH=8, SHW=3, SRA, data_in=0x90, shamt=2 -> 0xE4 after 3 cycles. Random regression of all modes against a reference model.
